cam_match_resolver: RTL and testbench



---
 rtl/cam_match_resolver.sv | 151 +++++++++++++++
 tb/tb_cam_match_resolver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_resolver.sv
// cam_match_resolver: accepts one CAM search key per request, broadcasts it to
// all rows for a single SEARCH cycle, captures the valid-gated match vector and
// reports every matching row index lowest-first (or one miss beat) over a
// valid/ready result channel.
// Optional build macro CAM_MATCH_COUNT_EN adds match_count_o, the population
// count of the captured vector, held constant for all beats of a search.
module cam_match_resolver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_key_i,
  output logic             search_enable_o,
  output logic [WIDTH-1:0] search_data_o,
  input  logic [DEPTH-1:0] match_i,
  input  logic [DEPTH-1:0] row_valid_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_hit_o,
  output logic [IDX_W-1:0] res_index_o,
  output logic             res_last_o
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [IDX_W:0]   match_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] pending;
  logic [WIDTH-1:0] key;
  logic [DEPTH-1:0] captured;
  logic [DEPTH-1:0] remaining;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Number of set bits; IDX_W+1 bits hold the all-ones case.
  function automatic logic [IDX_W:0] pop_count(input logic [DEPTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_single(input logic [DEPTH-1:0] v);
    return (pop_count(v) == (IDX_W + 1)'(1));
  endfunction

  // Single-bit mask selecting row idx.
  function automatic logic [DEPTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
    return {{(DEPTH - 1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rows are only trusted when their valid bit is set; the currently reported
  // index is always the lowest pending bit, so clearing it yields the rest.
  assign captured      = match_i & row_valid_i;
  assign remaining     = pending & ~bit_mask(res_index_o);
  assign search_data_o = key;

  // Control FSM with all handshake and result outputs held in registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= '0;
      key             <= '0;
      req_ready_o     <= 1'b1;
      search_enable_o <= 1'b0;
      res_valid_o     <= 1'b0;
      res_hit_o       <= 1'b0;
      res_index_o     <= '0;
      res_last_o      <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
      match_count_o   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            key             <= req_key_i;
            req_ready_o     <= 1'b0;
            search_enable_o <= 1'b1;
            state           <= SEARCH;
          end
        end
        SEARCH: begin
          // Rows answer combinationally, so the vector is valid this cycle.
          search_enable_o <= 1'b0;
          pending         <= captured;
          res_valid_o     <= 1'b1;
          res_hit_o       <= |captured;
          res_index_o     <= lowest_idx(captured);
          res_last_o      <= (captured == '0) || is_single(captured);
`ifdef CAM_MATCH_COUNT_EN
          match_count_o   <= pop_count(captured);
`endif
          state           <= REPORT;
        end
        REPORT: begin
          if (res_valid_o && res_ready_i) begin
            if (res_last_o) begin
              pending     <= '0;
              res_valid_o <= 1'b0;
              res_hit_o   <= 1'b0;
              res_index_o <= '0;
              res_last_o  <= 1'b0;
              req_ready_o <= 1'b1;
              state       <= IDLE;
            end else begin
              pending     <= remaining;
              res_index_o <= lowest_idx(remaining);
              res_last_o  <= is_single(remaining);
            end
          end
        end
        default: begin
          state           <= IDLE;
          pending         <= '0;
          req_ready_o     <= 1'b1;
          search_enable_o <= 1'b0;
          res_valid_o     <= 1'b0;
          res_hit_o       <= 1'b0;
          res_index_o     <= '0;
          res_last_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_match_resolver.sv
// Self-checking bench for cam_match_resolver (DEPTH=8, WIDTH=32): a table of
// directed searches, hand-written reset sequences and randomized searches, all
// checked against a transaction-level model that lists the expected beats.
module tb_cam_match_resolver;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_key_i;
  logic             search_enable_o;
  logic [WIDTH-1:0] search_data_o;
  logic [DEPTH-1:0] match_i;
  logic [DEPTH-1:0] row_valid_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic             res_hit_o;
  logic [IDX_W-1:0] res_index_o;
  logic             res_last_o;
`ifdef CAM_MATCH_COUNT_EN
  logic [IDX_W:0]   match_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cam_match_resolver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_key_i       (req_key_i),
    .search_enable_o (search_enable_o),
    .search_data_o   (search_data_o),
    .match_i         (match_i),
    .row_valid_i     (row_valid_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_hit_o       (res_hit_o),
    .res_index_o     (res_index_o),
    .res_last_o      (res_last_o)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_count_o   (match_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    logic [7:0]  match;
    logic [7:0]  valid;
    int          bp;       // 0 always ready, 1 random stalls, 2 first beat stalls 3 cycles
    logic [7:0]  exp_vec;  // rows expected to be reported
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks that every output is at its reset value.
  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_search_en"}, 32'(search_enable_o), 32'd0);
    chk({tag, "_search_data"}, search_data_o, 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
    chk({tag, "_res_hit"}, 32'(res_hit_o), 32'd0);
    chk({tag, "_res_index"}, 32'(res_index_o), 32'd0);
    chk({tag, "_res_last"}, 32'(res_last_o), 32'd0);
`ifdef CAM_MATCH_COUNT_EN
    chk({tag, "_match_count"}, 32'(match_count_o), 32'd0);
`endif
  endtask

  // One complete search, entered and left at a falling edge with the DUT idle.
  // The expected beat list is simply the set rows in ascending order, or one
  // miss beat; row inputs are scrambled after SEARCH to prove they are ignored.
  task automatic run_search(input logic [31:0] key, input logic [7:0] m, input logic [7:0] v,
                            input int bp, input logic [7:0] exp_vec);
    int beats[$];
    int stall;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_vec[i]) beats.push_back(i);
    end
    if (beats.size() == 0) beats.push_back(-1);

    req_valid_i = 1'b1;
    req_key_i   = key;
    match_i     = m;
    row_valid_i = v;
    res_ready_i = 1'($urandom_range(0, 1));
    chk("idle_req_ready", 32'(req_ready_o), 32'd1);
    chk("idle_res_valid", 32'(res_valid_o), 32'd0);
    @(negedge clk);
    chk("search_en", 32'(search_enable_o), 32'd1);
    chk("search_data", search_data_o, key);
    chk("search_req_ready", 32'(req_ready_o), 32'd0);
    chk("search_res_valid", 32'(res_valid_o), 32'd0);
    req_valid_i = 1'($urandom_range(0, 1));
    req_key_i   = $urandom;
    @(negedge clk);
    for (int b = 0; b < beats.size(); b++) begin
      stall = (bp == 2 && b == 0) ? 3 : (bp == 1) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s <= stall; s++) begin
        match_i     = 8'($urandom);
        row_valid_i = 8'($urandom);
        req_valid_i = 1'($urandom_range(0, 1));
        req_key_i   = $urandom;
        res_ready_i = (s == stall);
        chk("beat_valid", 32'(res_valid_o), 32'd1);
        chk("beat_hit", 32'(res_hit_o), (beats[b] >= 0) ? 32'd1 : 32'd0);
        chk("beat_index", 32'(res_index_o), (beats[b] >= 0) ? 32'(beats[b]) : 32'd0);
        chk("beat_last", 32'(res_last_o), (b == beats.size() - 1) ? 32'd1 : 32'd0);
        chk("beat_search_en", 32'(search_enable_o), 32'd0);
        chk("beat_search_data", search_data_o, key);
        chk("beat_req_ready", 32'(req_ready_o), 32'd0);
`ifdef CAM_MATCH_COUNT_EN
        chk("beat_match_count", 32'(match_count_o), 32'($countones(exp_vec)));
`endif
        @(negedge clk);
      end
    end
    req_valid_i = 1'b0;
    chk("done_res_valid", 32'(res_valid_o), 32'd0);
    chk("done_req_ready", 32'(req_ready_o), 32'd1);
    chk("done_search_en", 32'(search_enable_o), 32'd0);
    chk("done_search_data", search_data_o, key);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    logic [7:0] v;

    tbl[0] = '{32'hDEADBEEF, 8'h00, 8'hFF, 0, 8'h00};        // miss
    tbl[1] = '{32'h12345678, 8'hA5, 8'hFF, 0, 8'hA5};        // multi-hit 0,2,5,7
    tbl[2] = '{32'hCAFEF00D, 8'hFF, 8'h80, 0, 8'h80};        // valid gating -> 7
    tbl[3] = '{32'h0BADF00D, 8'h06, 8'hFF, 2, 8'h06};        // backpressure
    tbl[4] = '{32'h00000001, 8'h01, 8'hFF, 1, 8'h01};        // lowest row only
    tbl[5] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 1, 8'hFF};        // every row

    reset       = 1'b1;
    req_valid_i = 1'b0;
    req_key_i   = '0;
    match_i     = '0;
    row_valid_i = '0;
    res_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed table, back to back: each request is presented as soon as ready returns.
    for (int t = 0; t < 6; t++) begin
      run_search(tbl[t].key, tbl[t].match, tbl[t].valid, tbl[t].bp, tbl[t].exp_vec);
    end

    // Reset mid-REPORT: beats 0,1,2 accepted, reset while beat 3 is shown.
    req_valid_i = 1'b1;
    req_key_i   = 32'hA5A5A5A5;
    match_i     = 8'hFF;
    row_valid_i = 8'hFF;
    res_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      chk("rst_rep_index", 32'(res_index_o), 32'(b));
      @(negedge clk);
    end
    chk("rst_rep_index3", 32'(res_index_o), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("rst_report");
    reset = 1'b0;
    run_search(32'h00000010, 8'h10, 8'hFF, 0, 8'h10);

    // Reset mid-SEARCH: no beat may follow.
    req_valid_i = 1'b1;
    req_key_i   = 32'h5555AAAA;
    match_i     = 8'h3C;
    row_valid_i = 8'hFF;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rst_search_en", 32'(search_enable_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("rst_search");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_search_no_beat", 32'(res_valid_o), 32'd0);

    // Randomized searches against the model.
    for (int r = 0; r < 40; r++) begin
      m = 8'($urandom);
      v = 8'($urandom);
      if (r % 5 == 0) m = 8'h00;
      run_search($urandom, m, v, 1, m & v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
